// File: rtl/muldiv_unit.sv
// Multi-cycle integer multiply/divide engine for the EX stage.
// MULT/MULTU go through a MUL_LAT-deep product pipeline. DIV/DIVU run radix-2
// restoring division on magnitudes, one quotient bit per cycle, then a FIX
// cycle applies the signs. hi/lo/div_by_zero change only on a done pulse.
module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam int PIPE_D = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   prod_pipe [PIPE_D];
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     dvs;
  logic                 neg_q;
  logic                 neg_r;

  logic                 is_div;
  logic                 a_neg;
  logic                 b_neg;
  logic [2*WIDTH-1:0]   a_ext;
  logic [2*WIDTH-1:0]   b_ext;
  logic [2*WIDTH-1:0]   prod_now;
  logic [2*WIDTH-1:0]   mul_res;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH-1:0]     rem_in;
  logic [WIDTH-1:0]     quo_in;
  logic [WIDTH-1:0]     dvs_in;
  logic [WIDTH:0]       trial;
  logic [WIDTH-1:0]     rem_nxt;
  logic [WIDTH-1:0]     quo_nxt;
  logic [WIDTH-1:0]     q_fix;
  logic [WIDTH-1:0]     r_fix;

  // Operand conditioning, the shared divide step and the final sign fix.
  // The step takes the raw dividend in IDLE so the first quotient bit is
  // produced on the accept edge, leaving room for the FIX cycle.
  always_comb begin
    // NOTE: every output of this block gets a value on every path; a missing
    // default would infer a latch.
    is_div   = op[1];
    a_neg    = ~op[0] & a[WIDTH-1];
    b_neg    = ~op[0] & b[WIDTH-1];
    a_ext    = {{WIDTH{a_neg}}, a};
    b_ext    = {{WIDTH{b_neg}}, b};
    prod_now = a_ext * b_ext;
    mul_res  = (MUL_LAT == 1) ? prod_now : prod_pipe[PIPE_D-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    rem_in   = rem;
    quo_in   = quo;
    dvs_in   = dvs;
    if (state == S_IDLE) begin
      rem_in = '0;
      quo_in = a_mag;
      dvs_in = b_mag;
    end
    trial   = {rem_in, quo_in[WIDTH-1]} - {1'b0, dvs_in};
    rem_nxt = trial[WIDTH] ? {rem_in[WIDTH-2:0], quo_in[WIDTH-1]} : trial[WIDTH-1:0];
    quo_nxt = {quo_in[WIDTH-2:0], ~trial[WIDTH]};
    q_fix   = neg_q ? -quo : quo;
    r_fix   = neg_r ? -rem : rem;
  end

  // Control FSM with registered busy/done/result outputs.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      // NOTE: the product pipeline is a handful of registers, not a RAM, and
      // reset has to clear it, so it is reset like any other state.
      for (int i = 0; i < PIPE_D; i++) prod_pipe[i] <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
        busy  <= 1'b0;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              cnt <= CNT_W'(1);
              if (!is_div) begin
                prod_pipe[0] <= prod_now;
                if (MUL_LAT == 1) begin
                  hi          <= prod_now[2*WIDTH-1:WIDTH];
                  lo          <= prod_now[WIDTH-1:0];
                  div_by_zero <= 1'b0;
                  done        <= 1'b1;
                end else begin
                  state <= S_MUL;
                  busy  <= 1'b1;
                end
              end else if (b == '0) begin
                hi          <= a;
                lo          <= '1;
                div_by_zero <= 1'b1;
                done        <= 1'b1;
              end else begin
                rem   <= rem_nxt;
                quo   <= quo_nxt;
                dvs   <= b_mag;
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
                state <= S_DIV;
                busy  <= 1'b1;
              end
            end
          end
          S_MUL: begin
            for (int i = 1; i < PIPE_D; i++) prod_pipe[i] <= prod_pipe[i-1];
            if (cnt == CNT_W'(MUL_LAT - 1)) begin
              hi          <= mul_res[2*WIDTH-1:WIDTH];
              lo          <= mul_res[WIDTH-1:0];
              div_by_zero <= 1'b0;
              done        <= 1'b1;
              busy        <= 1'b0;
              state       <= S_IDLE;
              cnt         <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_DIV: begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIX;
          end
          S_FIX: begin
            hi          <= r_fix;
            lo          <= q_fix;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
            cnt         <= '0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver models acceptance/flush/reset
// at the level of "op in flight with latency L" and queues the expected
// result computed with plain integer arithmetic; a negedge monitor pops and
// compares on every done and checks busy and hold behaviour every cycle.
module tb_muldiv_unit;

  localparam int W       = 32;
  localparam int ML      = 2;
  localparam int DIV_LAT = W + 1;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_by_zero;

  muldiv_unit #(.WIDTH(W), .MUL_LAT(ML)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int           dc;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  exp_t         exp_q[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           n_done = 0;
  logic         pend = 1'b0;
  int           pend_k = 0;
  int           pend_lat = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;
  logic         last_dbz = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic on the architectural rules.
  function automatic exp_t ref_model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        r;
    longint      sx, sy, sp, sq, sr;
    logic [63:0] ux, uy, up, v;
    r     = '0;
    sx    = $signed({{32{x[W-1]}}, x});
    sy    = $signed({{32{y[W-1]}}, y});
    ux    = {32'b0, x};
    uy    = {32'b0, y};
    case (o)
      OP_MULT: begin
        sp = sx * sy; v = sp;
        r.hi = v[63:32]; r.lo = v[31:0];
      end
      OP_MULTU: begin
        up = ux * uy;
        r.hi = up[63:32]; r.lo = up[31:0];
      end
      default: begin
        if (y == '0) begin
          r.dbz = 1'b1; r.hi = x; r.lo = '1;
        end else if (o == OP_DIV) begin
          sq = sx / sy; sr = sx % sy;
          v = sq; r.lo = v[31:0];
          v = sr; r.hi = v[31:0];
        end else begin
          v = ux / uy; r.lo = v[31:0];
          v = ux % uy; r.hi = v[31:0];
        end
      end
    endcase
    return r;
  endfunction

  function automatic int lat_of(input logic [1:0] o, input logic [W-1:0] y);
    if (!o[1]) return ML;
    return (y == '0) ? 1 : DIV_LAT;
  endfunction

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom % 8)
      0: return '0;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return W'($urandom % 16);
      default: return W'($urandom);
    endcase
  endfunction

  // One clock: drive inputs, take the edge, advance the transaction model.
  task automatic tick(input logic s, input logic [1:0] o, input logic [W-1:0] x,
                      input logic [W-1:0] y, input logic f = 1'b0, input logic r = 1'b0);
    exp_t e;
    start = s; op = o; a = x; b = y; flush = f; rst = r;
    @(posedge clk);
    cyc++;
    if (r) begin
      pend = 1'b0;
      exp_q.delete();
      last_hi = '0; last_lo = '0; last_dbz = 1'b0;
    end else begin
      if (pend && cyc >= pend_k + pend_lat) pend = 1'b0;
      if (f) begin
        if (pend) begin
          pend = 1'b0;
          if (exp_q.size() > 0) e = exp_q.pop_back();
        end
      end else if (s && !pend) begin
        e        = ref_model(o, x, y);
        pend_lat = lat_of(o, y);
        pend_k   = cyc;
        e.dc     = cyc + pend_lat;
        pend     = 1'b1;
        exp_q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 2'($urandom), rnd_opnd(), rnd_opnd());
  endtask

  // Monitor: compares the DUT against the scoreboard once per cycle.
  initial begin
    exp_t e;
    logic exp_busy;
    wait (cyc > 0);
    forever begin
      @(negedge clk);
      exp_busy = pend && (cyc + 1 < pend_k + pend_lat);
      check("busy", 64'(busy), 64'(exp_busy));
      if (done) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", 64'(done), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", 64'(cyc + 1), 64'(e.dc));
          check("hi", 64'(hi), 64'(e.hi));
          check("lo", 64'(lo), 64'(e.lo));
          check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
          last_hi = e.hi; last_lo = e.lo; last_dbz = e.dbz;
          n_done++;
        end
      end else begin
        if (exp_q.size() > 0 && exp_q[0].dc <= cyc + 1) begin
          check("done_missing", 64'(done), 64'(1));
          e = exp_q.pop_front();
        end
        check("hold_hi", 64'(hi), 64'(last_hi));
        check("hold_lo", 64'(lo), 64'(last_lo));
        check("hold_dbz", 64'(div_by_zero), 64'(last_dbz));
      end
    end
  end

  // Directed scenarios, then randomized traffic.
  initial begin
    tick(1'b0, OP_MULT, '0, '0, 1'b0, 1'b1);
    tick(1'b0, OP_MULT, '0, '0, 1'b0, 1'b1);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_dbz", 64'(div_by_zero), 64'(0));

    // MULT -3*5
    tick(1'b1, OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005);
    check("t1_busy_k1", 64'(busy), 64'(1));
    check("t1_nodone_k1", 64'(done), 64'(0));
    idle(1);
    check("t1_done", 64'(done), 64'(1));
    check("t1_busy_k2", 64'(busy), 64'(0));
    check("t1_hi", 64'(hi), 64'(32'hFFFF_FFFF));
    check("t1_lo", 64'(lo), 64'(32'hFFFF_FFF1));

    // MULTU max*max, then back-to-back MULT 2*3 in the done cycle
    tick(1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(1);
    check("t2_hi", 64'(hi), 64'(32'hFFFF_FFFE));
    check("t2_lo", 64'(lo), 64'(32'h0000_0001));
    tick(1'b1, OP_MULT, 32'd2, 32'd3);
    check("t2_hold_hi", 64'(hi), 64'(32'hFFFF_FFFE));
    idle(1);
    check("t2b_done", 64'(done), 64'(1));
    check("t2b_hi", 64'(hi), 64'(0));
    check("t2b_lo", 64'(lo), 64'(6));

    // DIV -7/2, then MIN/-1 started in the done cycle
    tick(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    idle(W);
    check("t3_done", 64'(done), 64'(1));
    check("t3_lo", 64'(lo), 64'(32'hFFFF_FFFD));
    check("t3_hi", 64'(hi), 64'(32'hFFFF_FFFF));
    tick(1'b1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(W);
    check("t3b_lo", 64'(lo), 64'(32'h8000_0000));
    check("t3b_hi", 64'(hi), 64'(0));

    // DIVU by zero, then DIVU 100/7
    tick(1'b1, OP_DIVU, 32'd100, 32'd0);
    check("t4_done", 64'(done), 64'(1));
    check("t4_dbz", 64'(div_by_zero), 64'(1));
    check("t4_lo", 64'(lo), 64'(32'hFFFF_FFFF));
    check("t4_hi", 64'(hi), 64'(100));
    tick(1'b1, OP_DIVU, 32'd100, 32'd7);
    idle(W);
    check("t4b_lo", 64'(lo), 64'(14));
    check("t4b_hi", 64'(hi), 64'(2));
    check("t4b_dbz", 64'(div_by_zero), 64'(0));

    // flush at k+10, start+flush together, reset at k+5
    tick(1'b1, OP_DIVU, 32'd100, 32'd7);
    idle(9);
    tick(1'b0, OP_DIVU, '0, '0, 1'b1);
    check("t5_busy_after_flush", 64'(busy), 64'(0));
    idle(40);
    check("t5_hi_kept", 64'(hi), 64'(2));
    check("t5_lo_kept", 64'(lo), 64'(14));
    tick(1'b1, OP_DIVU, 32'd100, 32'd7, 1'b1);
    check("t5_start_flush", 64'(busy), 64'(0));
    idle(3);
    tick(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    idle(4);
    tick(1'b0, OP_DIV, '0, '0, 1'b0, 1'b1);
    check("t5_rst_busy", 64'(busy), 64'(0));
    check("t5_rst_hi", 64'(hi), 64'(0));
    check("t5_rst_lo", 64'(lo), 64'(0));
    check("t5_rst_done", 64'(done), 64'(0));
    idle(40);

    // Random traffic with random spacing, flushes and occasional reset
    for (int i = 0; i < 6000; i++) begin
      tick(($urandom % 3) == 0, 2'($urandom), rnd_opnd(), rnd_opnd(),
           ($urandom % 40) == 0, ($urandom % 1500) == 0);
    end
    idle(DIV_LAT + 5);
    check("drain_queue_empty", 64'(exp_q.size()), 64'(0));
    check("dones_seen_nonzero", 64'(n_done > 20), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
